// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: loads one WIDTH-bit word per tx handshake, shifts MSB-first, one bit every DIV clocks.
// Frame latency WIDTH*DIV clocks from accept to rx_valid; tx_ready only in IDLE, rx_valid has no backpressure.
module shift_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             abort,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             shift_strobe,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int DCW = $clog2(DIV) + 1;
    localparam int BCW = $clog2(WIDTH) + 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [DCW-1:0]   div_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic             accept;
    logic             last_shift;

    assign shifted    = {shreg[WIDTH-2:0], serial_in};
    assign serial_out = shreg[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        last_shift   = 1'b0;
        shift_strobe = 1'b0;
        tx_ready     = (state == IDLE);
        busy         = (state == SHIFT);
        case (state)
            IDLE: begin
                if (tx_valid && !abort) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_strobe = (div_cnt == DIV_LAST);
                // abort wins over a coincident final shift
                if (abort) begin
                    state_nxt = IDLE;
                end else if (shift_strobe && bit_cnt == BIT_LAST) begin
                    last_shift = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= last_shift;
            if (last_shift) rx_data <= shifted;
            if (accept) begin
                shreg   <= tx_data;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (abort) begin
                    shreg   <= '0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end else begin
                    div_cnt <= shift_strobe ? '0 : div_cnt + DCW'(1);
                    if (shift_strobe) begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench for shift_frame_ctrl: WIDTH=8/DIV=4 main instance plus a DIV=1 loopback instance.
module tb_shift_frame_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       abort;
    logic       lb;
    logic       sin_c;
    logic       serial_in;
    logic       serial_out;
    logic       shift_strobe;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic       abort1;
    logic       serial_in1;
    logic       serial_out1;
    logic       shift_strobe1;
    logic       busy1;
    logic [7:0] rx_data1;
    logic       rx_valid1;

    int checks = 0;
    int errors = 0;

    assign serial_in  = lb ? serial_out : sin_c;
    assign serial_in1 = serial_out1;

    shift_frame_ctrl #(.WIDTH(8), .DIV(4)) u0 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .abort(abort), .serial_in(serial_in), .serial_out(serial_out), .shift_strobe(shift_strobe),
        .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
    );

    shift_frame_ctrl #(.WIDTH(8), .DIV(1)) u1 (
        .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .abort(abort1), .serial_in(serial_in1), .serial_out(serial_out1), .shift_strobe(shift_strobe1),
        .busy(busy1), .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       lb;
        logic       sin;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    // One full frame; samples at negedges, cycle c is between edges E0+c and E0+c+1
    task automatic run_frame(input vec_t v);
        int idx;
        @(negedge clk);
        check("pre_tx_ready", tx_ready, 1);
        lb       = v.lb;
        sin_c    = v.sin;
        tx_data  = v.d;
        tx_valid = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid = 1'b0;
            idx = 7 - c / 4;
            check("serial_out_bit", serial_out, v.d[idx]);
            check("strobe_pos", shift_strobe, (c % 4 == 3) ? 1 : 0);
            check("busy_in_frame", busy, 1);
            check("tx_ready_in_frame", tx_ready, 0);
            check("rx_valid_early", rx_valid, 0);
        end
        @(negedge clk);
        check("rx_valid_pulse", rx_valid, 1);
        check("rx_data", rx_data, v.exp_rx);
        check("busy_after", busy, 0);
        check("tx_ready_after", tx_ready, 1);
        @(negedge clk);
        check("rx_valid_one_cycle", rx_valid, 0);
        check("rx_data_hold", rx_data, v.exp_rx);
    endtask

    initial begin
        int p1, p2, npulse;
        logic [7:0] r1, r2;

        vecs[0] = '{d: 8'hA5, lb: 1'b1, sin: 1'b0, exp_rx: 8'hA5};
        vecs[1] = '{d: 8'h00, lb: 1'b0, sin: 1'b1, exp_rx: 8'hFF};
        vecs[2] = '{d: 8'hF0, lb: 1'b0, sin: 1'b0, exp_rx: 8'h00};
        vecs[3] = '{d: 8'h3C, lb: 1'b1, sin: 1'b0, exp_rx: 8'h3C};

        reset     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        abort     = 1'b0;
        lb        = 1'b0;
        sin_c     = 1'b0;
        tx_data1  = 8'h00;
        tx_valid1 = 1'b0;
        abort1    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_serial_out", serial_out, 0);
        check("rst_strobe", shift_strobe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready1", tx_ready1, 1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // abort in IDLE blocks the accept
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_tx_ready", tx_ready, 1);
        tx_valid = 1'b0;
        abort    = 1'b0;

        // abort mid-frame at edge E0+10
        lb       = 1'b0;
        sin_c    = 1'b1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid = 1'b0;
        end
        check("pre_abort_serial_out", serial_out, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_tx_ready", tx_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_serial_out", serial_out, 0);
        check("abort_strobe", shift_strobe, 0);
        npulse = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rx_valid) npulse++;
        end
        check("abort_no_rx_valid", npulse, 0);
        check("abort_rx_data_kept", rx_data, 8'h3C);

        // tx_valid held: 0x3C then 0xC3 back to back
        lb       = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        p1 = -1; p2 = -1; r1 = 8'h00; r2 = 8'h00; npulse = 0;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            if (c == 0) tx_data = 8'hC3;
            if (c == 32) check("b2b_tx_ready_at_pulse", tx_ready, 1);
            if (c == 33) begin
                check("b2b_second_accept", busy, 1);
                tx_valid = 1'b0;
            end
            if (rx_valid) begin
                npulse++;
                if (p1 < 0) begin p1 = c; r1 = rx_data; end
                else begin p2 = c; r2 = rx_data; end
            end
        end
        tx_valid = 1'b0;
        check("b2b_pulses", npulse, 2);
        check("b2b_first_pos", p1, 32);
        check("b2b_spacing", p2 - p1, 33);
        check("b2b_rx1", r1, 8'h3C);
        check("b2b_rx2", r2, 8'hC3);

        // async reset mid-frame
        lb       = 1'b0;
        sin_c    = 1'b1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid = 1'b0;
        end
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_tx_ready", tx_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_serial_out", serial_out, 0);
        check("arst_strobe", shift_strobe, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_rx_data", rx_data, 0);
        @(negedge clk);
        reset  = 1'b1;
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rx_valid) npulse++;
        end
        check("post_reset_tx_ready", tx_ready, 1);
        check("post_reset_no_rx_valid", npulse, 0);

        // DIV=1 loopback
        tx_data1  = 8'h81;
        tx_valid1 = 1'b1;
        npulse    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid1 = 1'b0;
            check("div1_strobe", shift_strobe1, (c < 8) ? 1 : 0);
            check("div1_rx_valid", rx_valid1, (c == 8) ? 1 : 0);
            if (shift_strobe1) npulse++;
            if (c == 8) check("div1_rx_data", rx_data1, 8'h81);
        end
        check("div1_strobe_count", npulse, 8);
        check("div1_idle", tx_ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
